// File: rtl/seq_binary_divider_if.sv
// seq_binary_divider_if: start/busy/done handshake plus operands and results of the 7/3 divider
// Ports: master drives start, dividend[6:0], divisor[2:0]; slave drives busy, done, quotient[6:0], remainder[2:0], div_by_zero
interface seq_binary_divider_if;
    logic       start;
    logic [6:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [6:0] quotient;
    logic [2:0] remainder;
    logic       div_by_zero;
    modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
    modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_binary_divider.sv
// seq_binary_divider: restoring 7-bit by 3-bit unsigned divider, one quotient bit per clock, MSB first
// Ports: clk, rst (async active-high), bus (slave modport: start/dividend/divisor in, busy/done/quotient/remainder/div_by_zero out)
module seq_binary_divider (
    input logic                 clk,
    input logic                 rst,
    seq_binary_divider_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] state;
    logic [3:0] p;
    logic [6:0] w;
    logic [2:0] cnt;
    logic [2:0] dvs;
    logic [6:0] q_r;
    logic [2:0] r_r;
    logic       dz_r;
    logic [3:0] p_sh;
    logic       ge;
    logic [3:0] p_nx;
    logic [6:0] w_nx;
    // w shifts dividend bits out of the MSB while quotient bits enter at the LSB,
    // so after seven steps it holds the complete quotient
    always_comb begin
        p_sh = {p[2:0], w[6]};
        ge   = p_sh >= {1'b0, dvs};
        p_nx = ge ? p_sh - {1'b0, dvs} : p_sh;
        w_nx = {w[5:0], ge};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            w     <= '0;
            cnt   <= '0;
            dvs   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.divisor == 3'd0) begin
                        q_r   <= 7'h7F;
                        r_r   <= 3'd0;
                        dz_r  <= 1'b1;
                        state <= DONE;
                    end else begin
                        w     <= bus.dividend;
                        p     <= '0;
                        cnt   <= 3'd6;
                        dvs   <= bus.divisor;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p   <= p_nx;
                    w   <= w_nx;
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        q_r   <= w_nx;
                        r_r   <= p_nx[2:0];
                        dz_r  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy        = state == RUN;
    assign bus.done        = state == DONE;
    assign bus.quotient    = q_r;
    assign bus.remainder   = r_r;
    assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_binary_divider.sv
// tb_seq_binary_divider: scoreboard bench for seq_binary_divider against an arithmetic reference model
module tb_seq_binary_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    seq_binary_divider_if bus();
    seq_binary_divider dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [6:0] q;
        logic [2:0] r;
        logic       dz;
    } res_t;
    res_t exp_q[$];
    res_t last;
    int checks = 0;
    int passed = 0;
    task automatic chk(string name, int act, int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask
    function automatic res_t model(int a, int b);
        res_t m;
        if (b == 0) begin
            m.q = 7'h7F; m.r = 3'd0; m.dz = 1'b1;
        end else begin
            m.q = 7'(a / b); m.r = 3'(a % b); m.dz = 1'b0;
        end
        return m;
    endfunction
    // monitor: pops expected results on done, checks result stability while busy
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            last.q = '0; last.r = '0; last.dz = 1'b0;
        end else begin
            if (bus.busy && bus.done) chk("busy_done_overlap", 1, 0);
            if (bus.busy) begin
                chk("hold_quotient", bus.quotient, last.q);
                chk("hold_remainder", bus.remainder, last.r);
                chk("hold_div_by_zero", bus.div_by_zero, last.dz);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_by_zero", bus.div_by_zero, e.dz);
                    last = e;
                end
            end
        end
    end
    // called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    // mode 0: plain op, 1: extra start pulse during RUN, 2: async reset at E+4
    task automatic do_op(int a, int b, int mode);
        int lat = 0;
        int busy_n = 0;
        int dn = 0;
        bus.start = 1'b1;
        bus.dividend = a[6:0];
        bus.divisor = b[2:0];
        if (mode != 2) exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = 7'($urandom);
        bus.divisor = 3'($urandom);
        if (mode == 2) begin
            repeat (4) @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk("rst_quotient", bus.quotient, 0);
            chk("rst_remainder", bus.remainder, 0);
            chk("rst_div_by_zero", bus.div_by_zero, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            @(negedge clk);
            #1 rst = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (bus.done) dn++;
            end
            chk("no_done_after_reset", dn, 0);
        end else begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (mode == 1 && k == 3) begin
                    bus.start = 1'b1; bus.dividend = 7'd127; bus.divisor = 3'd7;
                end
                if (mode == 1 && k == 4) bus.start = 1'b0;
                if (bus.busy) busy_n++;
                if (bus.done) begin
                    lat = k;
                    break;
                end
            end
            chk("done_latency", lat, b == 0 ? 1 : 8);
            chk("busy_cycles", busy_n, b == 0 ? 0 : 7);
            @(negedge clk);
            chk("done_one_cycle", bus.done, 0);
        end
    endtask
    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset_quotient", bus.quotient, 0);
        chk("reset_remainder", bus.remainder, 0);
        chk("reset_div_by_zero", bus.div_by_zero, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        do_op(100, 5, 0);
        do_op(127, 7, 0);
        do_op(105, 7, 0);
        do_op(5, 6, 0);
        do_op(0, 1, 0);
        do_op(42, 0, 0);
        do_op(9, 2, 0);
        do_op(100, 5, 1);
        do_op(100, 5, 2);
        do_op(127, 7, 0);
        repeat (60) do_op(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), 0);
        for (int a = 0; a < 128; a++)
            for (int b = 1; b < 8; b++)
                do_op(a, b, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
